instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction memory: owns the program counter, drives `PC_addr`, and registers the returned `Instruction` into an IF/ID slot with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute, flushing the slot.
- Detects illegal fetch addresses and halts with a sticky fault.

---
 rtl/instruction_fetch_unit.sv | 84 ++++++++
 tb/tb_instruction_fetch_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, captures memory read data into an IF/ID slot
// with valid/ready toward decode, takes redirects from execute, faults on bad PCs.
//
// state | meaning
// BOOT  | one idle clock after reset; only a redirect is honoured
// RUN   | normal fetch, redirect, stall and fault detection
// FAULT | sticky illegal-fetch halt; only reset leaves it
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'd1000,
  parameter int unsigned MEM_DEPTH    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] PC_addr,
  input  logic [31:0] Instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] DEPTH = 32'(MEM_DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        slot_free;
  logic        legal;

  assign PC_addr   = pc_q;
  assign pc_next   = pc_q + 32'd4;
  assign slot_free = !id_valid || id_ready;
  // Range check on the unwrapped PC, so a wrap past 2^32 can never be fetched.
  assign legal     = (pc_q[1:0] == 2'b00) && (pc_q < DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc_q        <= RESET_VECTOR;
      id_valid    <= 1'b0;
      id_instr    <= 32'd0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          if (redirect_valid) pc_q <= redirect_target;
          state <= RUN;
        end
        RUN: begin
          if (redirect_valid) begin
            pc_q     <= redirect_target;
            id_valid <= 1'b0;
          end else if (slot_free && legal) begin
            id_instr    <= Instruction;
            id_pc       <= pc_q;
            id_pc_plus4 <= pc_next;
            id_valid    <= 1'b1;
            pc_q        <= pc_next;
          end else if (slot_free) begin
            id_valid    <= 1'b0;
            fetch_fault <= 1'b1;
            fault_pc    <= pc_q;
            state       <= FAULT;
          end
        end
        FAULT: begin
          if (id_ready) id_valid <= 1'b0;
        end
        default: state <= FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector table for fetch/stall/redirect, a
// handshake scoreboard, and hand sequences for fault, end-of-memory and async reset.
module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, redirect_valid, id_ready;
  logic [31:0] redirect_target, pc_addr, instruction;
  logic        id_valid, fetch_fault;
  logic [31:0] id_instr, id_pc, id_pc_plus4, fault_pc;

  logic        rst_n2, redirect_valid2, id_ready2;
  logic [31:0] redirect_target2, pc_addr2, instruction2;
  logic        id_valid2, fetch_fault2;
  logic [31:0] id_instr2, id_pc2, id_pc_plus42, fault_pc2;

  logic [31:0] mem [0:1023];
  assign instruction  = (pc_addr  < 32'd1024) ? mem[pc_addr[9:0]]  : 32'h0;
  assign instruction2 = (pc_addr2 < 32'd1024) ? mem[pc_addr2[9:0]] : 32'h0;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .PC_addr(pc_addr), .Instruction(instruction),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  instruction_fetch_unit #(.RESET_VECTOR(32'd1020), .MEM_DEPTH(1024)) dut_end (
    .clk(clk), .rst_n(rst_n2), .PC_addr(pc_addr2), .Instruction(instruction2),
    .redirect_valid(redirect_valid2), .redirect_target(redirect_target2),
    .id_valid(id_valid2), .id_ready(id_ready2), .id_instr(id_instr2), .id_pc(id_pc2),
    .id_pc_plus4(id_pc_plus42), .fetch_fault(fetch_fault2), .fault_pc(fault_pc2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rt;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic [31:0] ea;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_on = 1'b0;
  int   sb_pops = 0;

  // Every slot decode accepts must match the next expected fetch, in order.
  always @(negedge clk) begin
    exp_t e;
    if (sb_on && id_valid && id_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_extra actual_pc=%0d required=none", id_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_instr", id_instr, e.instr);
        chk("sb_pc", id_pc, e.pc);
        sb_pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  vec_t tbl [10];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1300_0000 + 32'(i);
    mem[1000] = 32'hFFC4A303;
    mem[1004] = 32'h0064A423;
    mem[1008] = 32'h0062E233;
    mem[1012] = 32'hFE420AE3;

    //             rdy   rv    rt         ev    instr          pc        pc_addr
    tbl[0] = '{1'b1, 1'b0, 32'd0,    1'b0, 32'h0,        32'd0,    32'd1000};
    tbl[1] = '{1'b1, 1'b0, 32'd0,    1'b1, 32'hFFC4A303, 32'd1000, 32'd1004};
    tbl[2] = '{1'b1, 1'b0, 32'd0,    1'b1, 32'h0064A423, 32'd1004, 32'd1008};
    tbl[3] = '{1'b0, 1'b0, 32'd0,    1'b1, 32'h0064A423, 32'd1004, 32'd1008};
    tbl[4] = '{1'b0, 1'b0, 32'd0,    1'b1, 32'h0064A423, 32'd1004, 32'd1008};
    tbl[5] = '{1'b0, 1'b0, 32'd0,    1'b1, 32'h0064A423, 32'd1004, 32'd1008};
    tbl[6] = '{1'b1, 1'b0, 32'd0,    1'b1, 32'h0062E233, 32'd1008, 32'd1012};
    tbl[7] = '{1'b1, 1'b0, 32'd0,    1'b1, 32'hFE420AE3, 32'd1012, 32'd1016};
    tbl[8] = '{1'b0, 1'b1, 32'd1000, 1'b0, 32'h0,        32'd0,    32'd1000};
    tbl[9] = '{1'b1, 1'b0, 32'd0,    1'b1, 32'hFFC4A303, 32'd1000, 32'd1004};

    rst_n = 1'b0; rst_n2 = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'd0; id_ready = 1'b1;
    redirect_valid2 = 1'b0; redirect_target2 = 32'd0; id_ready2 = 1'b1;
    #23;
    chk("rst_pc_addr", pc_addr, 32'd1000);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc_plus4", id_pc_plus4, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);

    tick();
    rst_n = 1'b1;
    sb_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      id_ready = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_target = tbl[i].rt;
      if (i > 0 && tbl[i].rdy && tbl[i-1].ev) sb_q.push_back('{tbl[i-1].ei, tbl[i-1].ep});
      tick();
      chk($sformatf("v%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].ev});
      chk($sformatf("v%0d_pc_addr", i), pc_addr, tbl[i].ea);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_instr", i), id_instr, tbl[i].ei);
        chk($sformatf("v%0d_pc", i), id_pc, tbl[i].ep);
        chk($sformatf("v%0d_pc_plus4", i), id_pc_plus4, tbl[i].ep + 32'd4);
      end
    end
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    sb_on = 1'b0;
    chk("sb_left", 32'(sb_q.size()), 32'd0);
    chk("sb_pops", 32'(sb_pops), 32'd3);

    // Misaligned redirect target faults on the next capture attempt.
    redirect_valid = 1'b1; redirect_target = 32'd1002;
    tick();
    chk("mis_valid", {31'b0, id_valid}, 32'd0);
    chk("mis_pc_addr", pc_addr, 32'd1002);
    chk("mis_no_fault_yet", {31'b0, fetch_fault}, 32'd0);
    redirect_valid = 1'b0;
    tick();
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'd1002);
    chk("mis_fault_valid", {31'b0, id_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_target = 32'd1000; id_ready = 1'b1;
    tick();
    tick();
    chk("fault_redirect_ignored", pc_addr, 32'd1002);
    chk("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    chk("fault_no_capture", {31'b0, id_valid}, 32'd0);
    redirect_valid = 1'b0;

    // Last legal word, then the out-of-range PC right after it.
    rst_n2 = 1'b1;
    tick();
    chk("end_boot_valid", {31'b0, id_valid2}, 32'd0);
    chk("end_boot_pc_addr", pc_addr2, 32'd1020);
    tick();
    chk("end_cap_valid", {31'b0, id_valid2}, 32'd1);
    chk("end_cap_pc", id_pc2, 32'd1020);
    chk("end_cap_instr", id_instr2, 32'h1300_03FC);
    chk("end_cap_pc_plus4", id_pc_plus42, 32'd1024);
    chk("end_cap_no_fault", {31'b0, fetch_fault2}, 32'd0);
    tick();
    chk("end_fault", {31'b0, fetch_fault2}, 32'd1);
    chk("end_fault_pc", fault_pc2, 32'd1024);
    chk("end_fault_valid", {31'b0, id_valid2}, 32'd0);
    redirect_valid2 = 1'b1; redirect_target2 = 32'd1000;
    tick();
    chk("end_pc_frozen", pc_addr2, 32'd1024);
    redirect_valid2 = 1'b0;

    // Async reset while decode is stalling a valid slot.
    rst_n = 1'b0;
    #2;
    chk("rst2_fault_clear", {31'b0, fetch_fault}, 32'd0);
    rst_n = 1'b1; id_ready = 1'b1;
    tick();
    chk("rst2_boot_valid", {31'b0, id_valid}, 32'd0);
    tick();
    chk("rst2_cap_instr", id_instr, 32'hFFC4A303);
    id_ready = 1'b0;
    tick();
    chk("stall_valid", {31'b0, id_valid}, 32'd1);
    chk("stall_pc_addr", pc_addr, 32'd1004);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_instr", id_instr, 32'd0);
    chk("arst_pc", id_pc, 32'd0);
    chk("arst_pc_plus4", id_pc_plus4, 32'd0);
    chk("arst_pc_addr", pc_addr, 32'd1000);
    chk("arst_fault_pc", fault_pc, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_boot_valid", {31'b0, id_valid}, 32'd0);
    chk("arst_boot_pc_addr", pc_addr, 32'd1000);
    id_ready = 1'b1;
    tick();
    chk("arst_fetch_valid", {31'b0, id_valid}, 32'd1);
    chk("arst_fetch_instr", id_instr, 32'hFFC4A303);
    chk("arst_fetch_pc", id_pc, 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
